hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Consumes the per-instruction operand-need stage (Tuse) and result-ready stage (Tnew) info
//  that decode emits. Tracks in-flight writers through E/M/W and raises a decode stall when
//  a needed operand cannot be forwarded in time. Otherwise drives forwarding selects for D, E, M.
//  Sits beside the pipeline registers; owns shadow copies of reg addrs/stages only, never data.
// PARAMETERS
//  W_TO_D_FWD   1   1: forward W result to D readers; 0: GRF write-through bypass covers it
//  STALL_CNT_W  32  width of stall counter (only with HAZARD_STATS_EN)
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high
//  d_read_addr0/1   in   5   rs/rt addr of instr in D
//  d_read_stage0/1  in   2   stage by which rs/rt is needed: DECODE=0 EXECUTE=1 MEM=2 MAX=3 (unused)
//  d_write_addr     in   5   dest reg of instr in D; 0 = no write
//  d_write_stage    in   2   stage at whose end the result exists (DECODE/EXECUTE/MEM)
//  stall            out  1   freeze PC and F/D, insert bubble into D/E
//  fwd_d0/fwd_d1    out  2   D rs/rt source: 0 GRF, 1 E-reg, 2 M-reg, 3 W-reg
//  fwd_e0/fwd_e1    out  2   E rs/rt source: 0 D/E reg, 2 M-reg, 3 W-reg
//  fwd_m1           out  2   M rt (store data) source: 0 E/M reg, 3 W-reg
//  stall_count      out  STALL_CNT_W  stall cycles since reset (HAZARD_STATS_EN only)
// BEHAVIOUR
//  - State per stage: E{rs,rt,waddr,wstage}, M{rt,waddr,wstage}, W{waddr}; all updated at posedge.
//  - Advance every cycle: M->W, E->M; D->E when !stall; when stall, E entry := bubble (all addrs 0).
//  - Reset: all tracked addrs/stages 0; stall=0, every fwd_*=0, stall_count=0; takes effect next edge
//    regardless of in-flight entries (reset mid-operation drops all hazards).
//  - Match: reader addr == producer waddr and addr != 0. Register 0 never matches, never stalls.
//  - Producer at stage index P (E=1,M=2,W=3) is ready now iff wstage < P.
//  - Stall (combinational from state + D inputs): for each D source with read_stage U != MAX, take the
//    YOUNGEST matching producer (E before M before W); stall iff its wstage >= P + U.
//    Older matches are ignored once a younger one exists.
//  - Forwarding: reader picks youngest matching producer strictly older than itself. If that producer
//    is ready, select its code; if not ready, select 0 (stall already guarantees it is unused).
//  - fwd_d* to W: code 3 if W_TO_D_FWD=1, else 0. fwd_d* ignores read_stage (selects valid always).
//  - Stall cannot persist >2 cycles for a single hazard (max wstage MEM=2, P>=1).
//  - No enable/flush inputs; one instruction in D per cycle; stall is the only backpressure.
// CONFIGURATION
//  HAZARD_STATS_EN defined: stall_count increments by 1 each cycle stall=1, wraps at 2^STALL_CNT_W,
//  cleared by reset. Undefined: stall_count port absent; no counter logic.
// TESTING
//  1. lw $8 -> next beq $8,$9 (U=0): stall=1 two cycles, then fwd_d0=3 (W_TO_D_FWD=1).
//  2. addu $8 -> next addu $10,$8,$8: no stall; in E fwd_e0=fwd_e1=2.
//  3. jal ($31, wstage 0) -> next jr $31: no stall, fwd_d0=1.
//  4. addu $8 then lw $8 then sw $8,0($9): sw data fwd_m1=3 from lw, not the addu.
//  5. D reads $0 while E writes $0 with wstage=MEM: stall=0, all fwd=0.
//  6. reset asserted while lw $8 in E, beq $8 in D: next cycle stall=0, stats count frozen then 0.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard unit port bundle: decode-side operand info in, stall/forward selects out.
// Optional: HAZARD_STATS_EN adds the stall_count signal.
interface hazard_if
`ifdef HAZARD_STATS_EN
  #(parameter int STALL_CNT_W = 32)
`endif
  ();
  logic [4:0] d_read_addr0;
  logic [4:0] d_read_addr1;
  logic [1:0] d_read_stage0;
  logic [1:0] d_read_stage1;
  logic [4:0] d_write_addr;
  logic [1:0] d_write_stage;
  logic       stall;
  logic [1:0] fwd_d0;
  logic [1:0] fwd_d1;
  logic [1:0] fwd_e0;
  logic [1:0] fwd_e1;
  logic [1:0] fwd_m1;
`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1, d_write_addr, d_write_stage,
    input  stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1, stall_count
  );
  modport slave (
    input  d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1, d_write_addr, d_write_stage,
    output stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1, stall_count
  );
`else
  modport master (
    output d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1, d_write_addr, d_write_stage,
    input  stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1
  );
  modport slave (
    input  d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1, d_write_addr, d_write_stage,
    output stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1
  );
`endif
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks writer reg addrs/ready stages through E/M/W, raises a
// decode stall when an operand cannot be forwarded in time, and drives forward selects.
// Optional: HAZARD_STATS_EN adds a wrapping stall-cycle counter on stall_count.
module hazard_unit #(
  parameter bit W_TO_D_FWD = 1'b1
`ifdef HAZARD_STATS_EN
  , parameter int STALL_CNT_W = 32
`endif
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave bus
);
  // Shadow copies of the in-flight instructions (addresses and ready stages only).
  logic [4:0] e_rs_reg, e_rt_reg, e_waddr_reg, m_rt_reg, m_waddr_reg, w_waddr_reg;
  logic [1:0] e_wstage_reg, m_wstage_reg;
  logic       stall;

  // A D source stalls when its youngest matching producer cannot deliver by the
  // time the value is needed; older matches are shadowed by younger ones. A W
  // producer always has its result, so a W match only shadows nothing older.
  function automatic logic src_stall(input logic [4:0] a, input logic [1:0] u,
                                     input logic [4:0] ew, input logic [1:0] es,
                                     input logic [4:0] mw, input logic [1:0] ms);
    src_stall = 1'b0;
    if (u != 2'd3 && a != 5'd0) begin
      if (a == ew)
        src_stall = ({1'b0, es} >= 3'd1 + {1'b0, u});
      else if (a == mw)
        src_stall = ({1'b0, ms} >= 3'd2 + {1'b0, u});
    end
  endfunction

  // D forward select: youngest of E/M/W; a not-yet-ready producer yields 0
  // because the stall keeps that value from being consumed.
  function automatic logic [1:0] d_sel(input logic [4:0] a,
                                       input logic [4:0] ew, input logic [1:0] es,
                                       input logic [4:0] mw, input logic [1:0] ms,
                                       input logic [4:0] ww);
    d_sel = 2'd0;
    if (a != 5'd0) begin
      if (a == ew)
        d_sel = (es < 2'd1) ? 2'd1 : 2'd0;
      else if (a == mw)
        d_sel = (ms < 2'd2) ? 2'd2 : 2'd0;
      else if (a == ww)
        d_sel = W_TO_D_FWD ? 2'd3 : 2'd0;
    end
  endfunction

  // E forward select: only M and W are older than an instruction in E.
  function automatic logic [1:0] e_sel(input logic [4:0] a,
                                       input logic [4:0] mw, input logic [1:0] ms,
                                       input logic [4:0] ww);
    e_sel = 2'd0;
    if (a != 5'd0) begin
      if (a == mw)
        e_sel = (ms < 2'd2) ? 2'd2 : 2'd0;
      else if (a == ww)
        e_sel = 2'd3;
    end
  endfunction

  // Stall and forwarding selects, combinational from tracked state and D inputs.
  always_comb begin
    stall = src_stall(bus.d_read_addr0, bus.d_read_stage0,
                      e_waddr_reg, e_wstage_reg, m_waddr_reg, m_wstage_reg)
          | src_stall(bus.d_read_addr1, bus.d_read_stage1,
                      e_waddr_reg, e_wstage_reg, m_waddr_reg, m_wstage_reg);
    bus.stall  = stall;
    bus.fwd_d0 = d_sel(bus.d_read_addr0, e_waddr_reg, e_wstage_reg,
                       m_waddr_reg, m_wstage_reg, w_waddr_reg);
    bus.fwd_d1 = d_sel(bus.d_read_addr1, e_waddr_reg, e_wstage_reg,
                       m_waddr_reg, m_wstage_reg, w_waddr_reg);
    bus.fwd_e0 = e_sel(e_rs_reg, m_waddr_reg, m_wstage_reg, w_waddr_reg);
    bus.fwd_e1 = e_sel(e_rt_reg, m_waddr_reg, m_wstage_reg, w_waddr_reg);
    bus.fwd_m1 = (m_rt_reg != 5'd0 && m_rt_reg == w_waddr_reg) ? 2'd3 : 2'd0;
  end

  // Advance the shadow pipeline; a stall turns the E entry into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_reg     <= '0;
      e_rt_reg     <= '0;
      e_waddr_reg  <= '0;
      e_wstage_reg <= '0;
      m_rt_reg     <= '0;
      m_waddr_reg  <= '0;
      m_wstage_reg <= '0;
      w_waddr_reg  <= '0;
    end else begin
      w_waddr_reg  <= m_waddr_reg;
      m_rt_reg     <= e_rt_reg;
      m_waddr_reg  <= e_waddr_reg;
      m_wstage_reg <= e_wstage_reg;
      if (stall) begin
        e_rs_reg     <= '0;
        e_rt_reg     <= '0;
        e_waddr_reg  <= '0;
        e_wstage_reg <= '0;
      end else begin
        e_rs_reg     <= bus.d_read_addr0;
        e_rt_reg     <= bus.d_read_addr1;
        e_waddr_reg  <= bus.d_write_addr;
        e_wstage_reg <= bus.d_write_stage;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_count_reg;

  // Count stalled cycles; wraps naturally at the counter width.
  always_ff @(posedge clk) begin
    if (reset)
      stall_count_reg <= '0;
    else if (stall)
      stall_count_reg <= stall_count_reg + 1'b1;
  end

  assign bus.stall_count = stall_count_reg;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed hazard scenarios then random instruction
// streams, checked against an instruction-level pipeline model.
module tb_hazard_unit;
  localparam bit W_TO_D_FWD = 1'b1;
`ifdef HAZARD_STATS_EN
  localparam int STALL_CNT_W = 32;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

`ifdef HAZARD_STATS_EN
  hazard_if #(.STALL_CNT_W(STALL_CNT_W)) hif ();
  hazard_unit #(.W_TO_D_FWD(W_TO_D_FWD), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(hif));
`else
  hazard_if hif ();
  hazard_unit #(.W_TO_D_FWD(W_TO_D_FWD)) dut (.clk(clk), .reset(reset), .bus(hif));
`endif

  always #5 clk = ~clk;

  // Model: whole instructions sitting in stage index 1=E, 2=M, 3=W.
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] ws;
  } instr_t;
  instr_t pipe [1:3];
  logic   exp_stall;
`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] exp_count;
`endif

  function automatic int youngest(input logic [4:0] a, input int lo);
    for (int p = lo; p <= 3; p++)
      if (a != 5'd0 && pipe[p].wa == a) return p;
    return 0;
  endfunction

  function automatic logic must_wait(input logic [4:0] a, input logic [1:0] u);
    int p;
    if (u == 2'd3) return 1'b0;
    p = youngest(a, 1);
    if (p == 0) return 1'b0;
    return int'(pipe[p].ws) >= p + int'(u);
  endfunction

  function automatic logic [1:0] sel(input logic [4:0] a, input int lo, input logic wfwd);
    int p;
    p = youngest(a, lo);
    if (p == 0 || int'(pipe[p].ws) >= p) return 2'd0;
    if (p == 3) return wfwd ? 2'd3 : 2'd0;
    return 2'(p);
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // One cycle: present D instruction, check outputs before the edge, advance model.
  task automatic step(input logic [4:0] a0, input logic [1:0] u0,
                      input logic [4:0] a1, input logic [1:0] u1,
                      input logic [4:0] wa, input logic [1:0] ws, input logic rst);
    instr_t d;
    @(negedge clk);
    hif.d_read_addr0 = a0; hif.d_read_stage0 = u0;
    hif.d_read_addr1 = a1; hif.d_read_stage1 = u1;
    hif.d_write_addr = wa; hif.d_write_stage = ws;
    reset = rst;
    #1;
    exp_stall = must_wait(a0, u0) || must_wait(a1, u1);
    chk("stall",  int'(hif.stall),  int'(exp_stall));
    chk("fwd_d0", int'(hif.fwd_d0), int'(sel(a0, 1, W_TO_D_FWD)));
    chk("fwd_d1", int'(hif.fwd_d1), int'(sel(a1, 1, W_TO_D_FWD)));
    chk("fwd_e0", int'(hif.fwd_e0), int'(sel(pipe[1].rs, 2, 1'b1)));
    chk("fwd_e1", int'(hif.fwd_e1), int'(sel(pipe[1].rt, 2, 1'b1)));
    chk("fwd_m1", int'(hif.fwd_m1), int'(sel(pipe[2].rt, 3, 1'b1)));
`ifdef HAZARD_STATS_EN
    chk("stall_count", int'(hif.stall_count), int'(exp_count));
`endif
    $display("[TB] d=(%0d/%0d,%0d/%0d -> %0d@%0d) rst=%0d stall=%0d fd=%0d,%0d fe=%0d,%0d fm=%0d",
             a0, u0, a1, u1, wa, ws, rst, hif.stall, hif.fwd_d0, hif.fwd_d1,
             hif.fwd_e0, hif.fwd_e1, hif.fwd_m1);
    d.rs = a0; d.rt = a1; d.wa = wa; d.ws = ws;
    if (rst) begin
      for (int i = 1; i <= 3; i++) pipe[i] = '{5'd0, 5'd0, 5'd0, 2'd0};
`ifdef HAZARD_STATS_EN
      exp_count = '0;
`endif
    end else begin
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = exp_stall ? '{5'd0, 5'd0, 5'd0, 2'd0} : d;
`ifdef HAZARD_STATS_EN
      if (exp_stall) exp_count = exp_count + 1'b1;
`endif
    end
  endtask

  task automatic nop(input logic rst);
    step(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, rst);
  endtask

  initial begin
    logic [4:0] a0, a1, wa;
    logic [1:0] u0, u1, ws;
    logic       rst;
    for (int i = 1; i <= 3; i++) pipe[i] = '{5'd0, 5'd0, 5'd0, 2'd0};
    exp_stall = 1'b0;
`ifdef HAZARD_STATS_EN
    exp_count = '0;
`endif
    hif.d_read_addr0 = '0; hif.d_read_addr1 = '0;
    hif.d_read_stage0 = 2'd3; hif.d_read_stage1 = 2'd3;
    hif.d_write_addr = '0; hif.d_write_stage = '0;
    // Reset; the model starts empty, matching the post-reset state.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    nop(1'b1);
    nop(1'b0);

    // lw $8 followed by beq $8,$9: two stall cycles, then W forward.
    step(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0);
    repeat (3) step(5'd8, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0);
    repeat (3) nop(1'b0);

    // addu $8 then addu $10,$8,$8: M forwards both E operands.
    step(5'd1, 2'd1, 5'd2, 2'd1, 5'd8, 2'd1, 1'b0);
    step(5'd8, 2'd1, 5'd8, 2'd1, 5'd10, 2'd1, 1'b0);
    repeat (3) nop(1'b0);

    // jal then jr $31: E result ready at decode.
    step(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 1'b0);
    step(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    repeat (3) nop(1'b0);

    // addu $8, lw $8, sw $8,0($9): store data comes from the lw in W.
    step(5'd1, 2'd1, 5'd2, 2'd1, 5'd8, 2'd1, 1'b0);
    step(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0);
    step(5'd9, 2'd1, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0);
    repeat (3) nop(1'b0);

    // Register 0 never matches even with a late producer.
    step(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0);
    step(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    repeat (3) nop(1'b0);

    // Stall into a reset: hazard dropped at the next edge.
    step(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0);
    step(5'd8, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0);
    step(5'd8, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b1);
    step(5'd8, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0);
    repeat (3) nop(1'b0);

    // Random streams over a few registers; a stalled instruction is re-presented.
    a0 = '0; a1 = '0; wa = '0; u0 = 2'd3; u1 = 2'd3; ws = '0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!exp_stall) begin
        a0 = 5'($urandom_range(0, 3)); u0 = 2'($urandom_range(0, 3));
        a1 = 5'($urandom_range(0, 3)); u1 = 2'($urandom_range(0, 3));
        wa = 5'($urandom_range(0, 3)); ws = 2'($urandom_range(0, 2));
      end
      step(a0, u0, a1, u1, wa, ws, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
